// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory arbiter: state encoding,
// word size and default burst/starvation limits.
package imem_pkg;

  localparam int IMEM_WORD_BYTES   = 4;
  localparam int IMEM_BURST_MAX    = 16;
  localparam int IMEM_STARVE_LIMIT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } imem_arb_state_t;

endpackage

// File: rtl/imem_arbiter.sv
// Arbitrates the single instruction-memory port between fetch (single-word
// reads) and the program loader (atomic multi-beat write bursts).
// Optional starvation guard: define IMEM_ARB_STARVE_EN so that fetch wins the
// next IDLE arbitration after STARVE_LIMIT denied request cycles.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int BURST_MAX = IMEM_BURST_MAX
`ifdef IMEM_ARB_STARVE_EN
  ,
  parameter int STARVE_LIMIT = IMEM_STARVE_LIMIT
`endif
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         f_req,
  input  logic [31:0]                  f_addr,
  output logic                         f_gnt,
  output logic                         f_rvalid,
  output logic [31:0]                  f_rdata,
  input  logic                         l_req,
  input  logic [31:0]                  l_addr,
  input  logic [$clog2(BURST_MAX):0]   l_len,
  output logic                         l_gnt,
  input  logic                         l_wvalid,
  input  logic [31:0]                  l_wdata,
  output logic                         l_wready,
  output logic                         l_done,
  output logic                         mem_enable,
  output logic                         mem_read_write,
  output logic [31:0]                  mem_address,
  output logic [31:0]                  mem_data_in,
  input  logic [31:0]                  mem_data_out,
  output logic                         busy
);

  localparam int LEN_W = $clog2(BURST_MAX) + 1;

  imem_arb_state_t  state;
  imem_arb_state_t  next_state;
  logic [31:0]      base_addr;
  logic [LEN_W-1:0] remaining;
  logic [LEN_W-1:0] beat_cnt;
  logic             rvalid_q;
  logic             loader_wins;
  logic             beat;

`ifdef IMEM_ARB_STARVE_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  logic [SC_W-1:0] starve_cnt;
  logic            fetch_starved;

  assign fetch_starved = (starve_cnt == SC_W'(STARVE_LIMIT));
`endif

  // Arbitration, memory-port steering and next-state selection; everything is
  // held quiet while reset is asserted so the port never fires during reset
  always_comb begin
    next_state     = state;
    f_gnt          = 1'b0;
    l_gnt          = 1'b0;
    l_wready       = 1'b0;
    l_done         = 1'b0;
    mem_enable     = 1'b0;
    mem_read_write = 1'b0;
    mem_address    = '0;
    mem_data_in    = '0;
    beat           = 1'b0;
    loader_wins    = l_req && (l_len != '0);
`ifdef IMEM_ARB_STARVE_EN
    if (fetch_starved) begin
      loader_wins = 1'b0;
    end
`endif
    if (reset) begin
      case (state)
        IDLE: begin
          if (loader_wins) begin
            l_gnt      = 1'b1;
            next_state = LOAD;
          end else if (f_req) begin
            f_gnt       = 1'b1;
            mem_enable  = 1'b1;
            mem_address = f_addr;
          end
        end
        LOAD: begin
          l_wready = 1'b1;
          if (l_wvalid) begin
            beat           = 1'b1;
            mem_enable     = 1'b1;
            mem_read_write = 1'b1;
            mem_address    = base_addr + 32'(beat_cnt) * 32'(IMEM_WORD_BYTES);
            mem_data_in    = l_wdata;
            if (remaining == LEN_W'(1)) begin
              next_state = DONE;
            end
          end
        end
        DONE: begin
          l_done     = 1'b1;
          next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // State register plus burst bookkeeping and the one-cycle read-valid delay
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      base_addr <= '0;
      remaining <= '0;
      beat_cnt  <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      state    <= next_state;
      rvalid_q <= f_gnt;
      if (l_gnt) begin
        base_addr <= l_addr;
        remaining <= l_len;
        beat_cnt  <= '0;
      end else if (beat) begin
        beat_cnt  <= beat_cnt + LEN_W'(1);
        remaining <= remaining - LEN_W'(1);
      end
    end
  end

`ifdef IMEM_ARB_STARVE_EN
  // Count cycles where fetch asked and was refused; saturates, clears on grant
  always_ff @(posedge clock) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (f_gnt) begin
      starve_cnt <= '0;
    end else if (f_req && (state == IDLE || state == LOAD) && !fetch_starved) begin
      starve_cnt <= starve_cnt + SC_W'(1);
    end
  end
`endif

  assign f_rvalid = rvalid_q;
  assign f_rdata  = rvalid_q ? mem_data_out : '0;
  assign busy     = (state != IDLE);

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Arbitrates the single instruction-memory port between the fetch stage (word reads) and a program loader (multi-beat word writes). Sits between fetch, the loader/debug front end, and `imemory`, driving its enable, read_write, address and data_in pins. Fetch reads are single-cycle grants. Loader writes are atomic bursts that fetch cannot interrupt. An optional starvation guard stops back-to-back bursts from locking out fetch.

## Interface
- `BURST_MAX`, 16: maximum beats per loader burst.
- `STARVE_LIMIT`, 8: consecutive denied fetch-request cycles before fetch gets priority (guard build only).

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low; sampled on the `clock` rising edge.
- `f_req` in 1: fetch wants a read this cycle.
- `f_addr` in 32: fetch read address.
- `f_gnt` out 1: read issued to memory this cycle (combinational).
- `f_rvalid` out 1: read data valid (registered).
- `f_rdata` out 32: read data, equal to `mem_data_out` in the `f_rvalid` cycle.
- `l_req` in 1: loader requests a burst.
- `l_addr` in 32: burst base address.
- `l_len` in $clog2(BURST_MAX)+1: burst length in beats.
- `l_gnt` out 1: one-cycle pulse when the burst is accepted.
- `l_wvalid` in 1: loader write beat valid.
- `l_wdata` in 32: write data.
- `l_wready` out 1: arbiter accepts a beat.
- `l_done` out 1: one-cycle pulse after the last beat.
- `mem_enable` out 1: to `imemory` enable.
- `mem_read_write` out 1: 1 = write, 0 = read.
- `mem_address` out 32: to `imemory` address.
- `mem_data_in` out 32: to `imemory` data_in.
- `mem_data_out` in 32: from `imemory`, valid one cycle after a read enable.
- `busy` out 1: high in any state except IDLE.

## Operation
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - If `l_req` is high and `l_len` is non-zero and the loader wins: latch `l_addr` into base, latch `l_len` into remaining, clear the beat counter, pulse `l_gnt`, go to LOAD. No fetch grant that cycle.
  - Else if `f_req` is high: `f_gnt`=1, `mem_enable`=1, `mem_read_write`=0, `mem_address`=`f_addr`.
  - `l_len`=0 is ignored: no `l_gnt`, state stays IDLE, fetch may be granted.
- Loader wins whenever `l_req` is valid, except in the guard build (see Configuration).
- LOAD:
  - `l_wready`=1 and `f_gnt`=0.
  - Each cycle with `l_wvalid` high is a beat: `mem_enable`=1, `mem_read_write`=1, `mem_address`=base+4·beat, `mem_data_in`=`l_wdata`.
  - Each beat increments the beat counter and decrements remaining.
  - Address arithmetic is 32-bit and wraps modulo 2^32 (0xFFFFFFFC+4 → 0x00000000).
  - A beat with remaining=1 moves the FSM to DONE.
  - `l_wvalid` low inserts a bubble: memory is idle, state is held, there is no timeout.
- DONE: `l_done`=1 for one cycle, then IDLE. No grants in DONE.
- When not granted, `mem_*` outputs are 0.
- `f_rvalid` is 1 exactly in the cycle after each `f_gnt`; `f_rdata` passes `mem_data_out` through.

## Timing
- Fetch read latency: `f_gnt` at cycle N, `f_rvalid`/`f_rdata` at N+1. Back-to-back reads give one word per cycle.
- Burst of L beats with no bubbles:
  - `l_gnt` at N.
  - Beats at N+1..N+L.
  - `l_done` at N+L+1.
  - IDLE (fetch grantable) at N+L+2.
- Simultaneous `l_req` and `f_req` in IDLE: the loader wins (guard disengaged), `f_gnt`=0.
- Reset (`reset`=0 at an edge): state=IDLE, counters=0, starve count=0. All outputs are 0 on the following cycle, including `f_rvalid`.
- Reset mid-burst: remaining beats are dropped and no `l_done` is issued. Memory contents already written are kept.

## Configuration
- `IMEM_ARB_STARVE_EN` defined:
  - A starve counter increments each IDLE or LOAD cycle with `f_req` high and `f_gnt` low. It saturates at `STARVE_LIMIT` and clears on `f_gnt`.
  - When the counter reaches `STARVE_LIMIT`, fetch beats `l_req` at the next IDLE arbitration.
  - A burst in progress is never pre-empted.
- Undefined: strict loader priority, no counter logic.

## Structure
- Shared package `imem_pkg`:
  - State enum `imem_arb_state_t` (IDLE, LOAD, DONE).
  - Constant `IMEM_WORD_BYTES`=4.
  - `BURST_MAX` default.
- No sub-module. Everything is one FSM plus counters in `imem_arbiter`.

## Test plan
- Fetch only: `f_req`=1 with addresses 0x01000000, 0x01000004, 0x01000008 on consecutive cycles → `f_gnt`=1 each cycle, `f_rvalid` one cycle later with the matching `mem_data_out`.
- Burst: `l_addr`=0x01000000, `l_len`=4, `l_wvalid` held high → writes to 0x01000000..0x0100000C on cycles N+1..N+4, `l_done` at N+5.
- Wrap and bubble: `l_addr`=0xFFFFFFF8, `l_len`=3, `l_wvalid` low on beat 2 for 2 cycles → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, with `l_done` two cycles later than the bubble-free case.
- Contention: `f_req` and `l_req` high together (`l_len`=2) → burst first. `f_gnt` first asserts the cycle after DONE.
- Guard build (`IMEM_ARB_STARVE_EN`, `STARVE_LIMIT`=8): `l_req` held high with `l_len`=4 and `f_req` held high → after 8 denied cycles, fetch is granted at the next IDLE.
- Reset mid-burst: `reset`=0 after beat 2 of 4 → no `l_done`, `busy`=0, all `mem_*`=0 the next cycle; a new burst is accepted after reset is released.
